// File: rtl/lsu_pkg.sv
// Shared definitions for the load/store unit: access size codes, error codes,
// FSM states and small decode/format helpers used on the request side.
package lsu_pkg;

  // Access size codes as presented on size_i
  localparam logic [2:0] SizeB  = 3'b000;
  localparam logic [2:0] SizeH  = 3'b001;
  localparam logic [2:0] SizeW  = 3'b010;
  localparam logic [2:0] SizeBu = 3'b100;
  localparam logic [2:0] SizeHu = 3'b101;

  typedef enum logic [1:0] {
    ErrNone     = 2'b00,
    ErrMisalign = 2'b01,
    ErrSize     = 2'b10,
    ErrTimeout  = 2'b11
  } lsu_err_e;

  typedef enum logic [1:0] {
    StIdle,
    StAccess,
    StDone
  } lsu_state_e;

  function automatic logic size_legal(input logic [2:0] size);
    return (size == SizeB) || (size == SizeH) || (size == SizeW) ||
           (size == SizeBu) || (size == SizeHu);
  endfunction

  // Only meaningful for legal sizes; size[1:0] is 00 byte, 01 half, 10 word.
  function automatic logic size_misaligned(input logic [2:0] size, input logic [1:0] off);
    logic mis;
    unique case (size[1:0])
      2'b01:   mis = off[0];
      2'b10:   mis = (off != 2'b00);
      default: mis = 1'b0;
    endcase
    return mis;
  endfunction

  function automatic logic [3:0] store_be(input logic [2:0] size, input logic [1:0] off);
    logic [3:0] be;
    unique case (size[1:0])
      2'b00:   be = 4'b0001 << off;
      2'b01:   be = off[1] ? 4'b1100 : 4'b0011;
      default: be = 4'b1111;
    endcase
    return be;
  endfunction

  // Replicate the right-aligned store datum into every lane it could land in.
  function automatic logic [31:0] store_wdata(input logic [2:0] size, input logic [31:0] wd);
    logic [31:0] rep;
    unique case (size[1:0])
      2'b00:   rep = {4{wd[7:0]}};
      2'b01:   rep = {2{wd[15:0]}};
      default: rep = wd;
    endcase
    return rep;
  endfunction

endpackage

// File: rtl/lsu_load_align.sv
// Load-data formatter: picks the addressed byte/halfword lane out of the bus
// read word and sign- or zero-extends it to 32 bits.
//   rdata_i  : raw bus read word
//   offset_i : byte offset within the word (addr[1:0] of the access)
//   size_i   : access size code (B/H/W/BU/HU)
//   data_o   : formatted 32-bit load result
module lsu_load_align
  import lsu_pkg::*;
(
  input  logic [31:0] rdata_i,
  input  logic [1:0]  offset_i,
  input  logic [2:0]  size_i,
  output logic [31:0] data_o
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;
  logic        sext;

  // size_i[2] set means the unsigned variants
  assign sext = ~size_i[2];

  always_comb begin
    byte_sel = rdata_i[7:0];
    unique case (offset_i)
      2'd0: byte_sel = rdata_i[7:0];
      2'd1: byte_sel = rdata_i[15:8];
      2'd2: byte_sel = rdata_i[23:16];
      2'd3: byte_sel = rdata_i[31:24];
      default: byte_sel = rdata_i[7:0];
    endcase
  end

  assign half_sel = offset_i[1] ? rdata_i[31:16] : rdata_i[15:0];

  always_comb begin
    data_o = rdata_i;
    unique case (size_i[1:0])
      2'b00:   data_o = {{24{sext & byte_sel[7]}}, byte_sel};
      2'b01:   data_o = {{16{sext & half_sel[15]}}, half_sel};
      default: data_o = rdata_i;
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// Memory access stage of the multicycle CPU. Accepts one load/store request
// from the control FSM, runs a single req/ready transaction on the data bus,
// formats load data for the memory data register and reports errors.
//   clk, rst          : clock, synchronous active-high reset
//   start_i .. wdata_i: request (pulse, direction, size code, address, data)
//   mem_*_o           : registered bus request, held while mem_req_o is high
//   mem_rdata_i/ready : bus response
//   load_data_o       : last successful load result
//   busy_o/done_o     : transaction in flight / one-cycle completion pulse
//   err_o/err_code_o  : error flag and code, valid with done_o
module load_store_unit
  import lsu_pkg::*;
#(
  parameter int unsigned TIMEOUT = 255,
  parameter int unsigned CNT_W   = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start_i,
  input  logic        we_i,
  input  logic [2:0]  size_i,
  input  logic [31:0] addr_i,
  input  logic [31:0] wdata_i,
  output logic        mem_req_o,
  output logic        mem_we_o,
  output logic [31:0] mem_addr_o,
  output logic [3:0]  mem_be_o,
  output logic [31:0] mem_wdata_o,
  input  logic [31:0] mem_rdata_i,
  input  logic        mem_ready_i,
  output logic [31:0] load_data_o,
  output logic        busy_o,
  output logic        done_o,
  output logic        err_o,
  output logic [1:0]  err_code_o
);

  localparam logic [CNT_W-1:0] CntLast = CNT_W'(TIMEOUT - 1);

  lsu_state_e        state_q, state_d;
  lsu_err_e          err_code_q, err_code_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              mem_req_q, mem_req_d;
  logic              mem_we_q, mem_we_d;
  logic [31:0]       mem_addr_q, mem_addr_d;
  logic [3:0]        mem_be_q, mem_be_d;
  logic [31:0]       mem_wdata_q, mem_wdata_d;
  logic [1:0]        off_q, off_d;
  logic [2:0]        size_q, size_d;
  logic [31:0]       load_data_q, load_data_d;
  logic [31:0]       load_fmt;

  // Offset and size are latched with the request so the formatter sees the
  // access's own attributes, not whatever the CPU drives during ACCESS.
  lsu_load_align u_load_align (
    .rdata_i  (mem_rdata_i),
    .offset_i (off_q),
    .size_i   (size_q),
    .data_o   (load_fmt)
  );

  always_comb begin
    state_d     = state_q;
    err_code_d  = err_code_q;
    cnt_d       = cnt_q;
    mem_req_d   = mem_req_q;
    mem_we_d    = mem_we_q;
    mem_addr_d  = mem_addr_q;
    mem_be_d    = mem_be_q;
    mem_wdata_d = mem_wdata_q;
    off_d       = off_q;
    size_d      = size_q;
    load_data_d = load_data_q;

    unique case (state_q)
      StIdle: begin
        err_code_d = ErrNone;
        if (start_i) begin
          if (!size_legal(size_i)) begin
            err_code_d = ErrSize;
            state_d    = StDone;
          end else if (size_misaligned(size_i, addr_i[1:0])) begin
            err_code_d = ErrMisalign;
            state_d    = StDone;
          end else begin
            mem_req_d   = 1'b1;
            mem_we_d    = we_i;
            mem_addr_d  = {addr_i[31:2], 2'b00};
            mem_be_d    = store_be(size_i, addr_i[1:0]);
            mem_wdata_d = we_i ? store_wdata(size_i, wdata_i) : 32'h0;
            off_d       = addr_i[1:0];
            size_d      = size_i;
            cnt_d       = '0;
            state_d     = StAccess;
          end
        end
      end

      StAccess: begin
        if (mem_ready_i) begin
          if (!mem_we_q) begin
            load_data_d = load_fmt;
          end
          mem_req_d  = 1'b0;
          err_code_d = ErrNone;
          state_d    = StDone;
        end else if (cnt_q == CntLast) begin
          mem_req_d  = 1'b0;
          err_code_d = ErrTimeout;
          state_d    = StDone;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      StDone: begin
        err_code_d = ErrNone;
        state_d    = StIdle;
      end

      default: begin
        err_code_d = ErrNone;
        mem_req_d  = 1'b0;
        state_d    = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= StIdle;
      err_code_q  <= ErrNone;
      cnt_q       <= '0;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= 32'h0;
      mem_be_q    <= 4'h0;
      mem_wdata_q <= 32'h0;
      off_q       <= 2'b00;
      size_q      <= 3'b000;
      load_data_q <= 32'h0;
    end else begin
      state_q     <= state_d;
      err_code_q  <= err_code_d;
      cnt_q       <= cnt_d;
      mem_req_q   <= mem_req_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_be_q    <= mem_be_d;
      mem_wdata_q <= mem_wdata_d;
      off_q       <= off_d;
      size_q      <= size_d;
      load_data_q <= load_data_d;
    end
  end

  assign mem_req_o   = mem_req_q;
  assign mem_we_o    = mem_we_q;
  assign mem_addr_o  = mem_addr_q;
  assign mem_be_o    = mem_be_q;
  assign mem_wdata_o = mem_wdata_q;
  assign load_data_o = load_data_q;
  assign busy_o      = (state_q != StIdle);
  assign done_o      = (state_q == StDone);
  // err_code_q is only non-zero in DONE, so it needs no gating on the output
  assign err_o       = done_o && (err_code_q != ErrNone);
  assign err_code_o  = err_code_q;

endmodule
